// File: rtl/data_cache_m_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache.
package data_cache_m_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    WRITE   = 2'd2,
    RESPOND = 2'd3
  } state_e;

  localparam int unsigned DEF_SETS       = 64;
  localparam int unsigned DEF_LINE_WORDS = 4;

endpackage

// File: rtl/cache_array.sv
// Tag, valid and data storage: one combinational read port, one byte-enabled write port.
module cache_array
  import data_cache_m_pkg::*;
#(
  parameter int unsigned SETS       = DEF_SETS,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  localparam int unsigned IDX_W     = $clog2(SETS),
  localparam int unsigned OFF_W     = $clog2(LINE_WORDS),
  localparam int unsigned TAG_W     = 32 - IDX_W - OFF_W - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] index,
  input  logic [OFF_W-1:0] rd_offset,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data,
  input  logic             invalidate,
  input  logic             tag_set,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS*LINE_WORDS];

  // Only the valid bits are reset; tag and data contents are don't-care until valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (tag_set) begin
      valid_q[index] <= 1'b1;
    end else if (invalidate) begin
      valid_q[index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_set) begin
      tag_q[index] <= wr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          data_q[{index, wr_offset}][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_valid = valid_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[{index, rd_offset}];

endmodule

// File: rtl/data_cache_m.sv
// Direct-mapped L1 data cache for the memory stage: write-through, no-write-allocate, read-allocate.
module data_cache_m
  import data_cache_m_pkg::*;
#(
  parameter int unsigned SETS       = DEF_SETS,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReq,
  input  logic        iWe,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  input  logic [3:0]  iByteEn,
  output logic [31:0] oReadData,
  output logic        oStall,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWData,
  output logic [3:0]  oMemBe,
  input  logic        iMemAck,
  input  logic [31:0] iMemRData
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W = 32 - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  state_e           state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit;

  logic             wr_en;
  logic [OFF_W-1:0] wr_offset;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;
  logic             invalidate;
  logic             tag_set;

  // Request fields are held by upstream while stalled, so they are used live, never latched.
  assign offset = iAddress[OFF_W+1:2];
  assign index  = iAddress[OFF_W+2 +: IDX_W];
  assign tag    = iAddress[31 -: TAG_W];
  assign hit    = rd_valid && (rd_tag == tag);

  cache_array #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk        (iClk),
    .rst        (iRst),
    .index      (index),
    .rd_offset  (offset),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_offset  (wr_offset),
    .wr_be      (wr_be),
    .wr_data    (wr_data),
    .invalidate (invalidate),
    .tag_set    (tag_set),
    .wr_tag     (tag)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    oReadData  = '0;
    oStall     = 1'b0;
    oMemReq    = 1'b0;
    oMemWe     = 1'b0;
    oMemAddr   = '0;
    oMemWData  = '0;
    oMemBe     = '0;
    wr_en      = 1'b0;
    wr_offset  = offset;
    wr_be      = iByteEn;
    wr_data    = iWriteData;
    invalidate = 1'b0;
    tag_set    = 1'b0;
    // Outputs are forced quiet while reset is held, independent of the request inputs.
    if (!iRst) begin
      unique case (state_q)
        IDLE: begin
          if (iReq) begin
            if (iWe) begin
              oStall  = 1'b1;
              state_d = WRITE;
            end else if (hit) begin
              oReadData = rd_data;
            end else begin
              // Drop the old line now so an abandoned refill never leaves a mixed line valid.
              oStall     = 1'b1;
              invalidate = 1'b1;
              cnt_d      = '0;
              state_d    = REFILL;
            end
          end
        end
        REFILL: begin
          oStall   = 1'b1;
          oMemReq  = 1'b1;
          oMemAddr = {tag, index, cnt_q, 2'b00};
          if (iMemAck) begin
            wr_en     = 1'b1;
            wr_offset = cnt_q;
            wr_be     = 4'hF;
            wr_data   = iMemRData;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST_BEAT) begin
              tag_set = 1'b1;
              state_d = RESPOND;
            end
          end
        end
        WRITE: begin
          oStall    = 1'b1;
          oMemReq   = 1'b1;
          oMemWe    = 1'b1;
          oMemAddr  = iAddress;
          oMemWData = iWriteData;
          oMemBe    = iByteEn;
          if (iMemAck) begin
            wr_en   = hit;
            state_d = RESPOND;
          end
        end
        RESPOND: begin
          if (!iWe) begin
            oReadData = rd_data;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache_m.sv
// Bench for data_cache_m: vector table plus hand sequences, backing-memory model and scoreboard.
module tb_data_cache_m;

  localparam int LW = 4;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iReq;
  logic        iWe;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic [3:0]  iByteEn;
  logic [31:0] oReadData;
  logic        oStall;
  logic        oMemReq;
  logic        oMemWe;
  logic [31:0] oMemAddr;
  logic [31:0] oMemWData;
  logic [3:0]  oMemBe;
  logic        iMemAck = 1'b0;
  logic [31:0] iMemRData = 32'h0;

  data_cache_m #(.SETS(64), .LINE_WORDS(LW)) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iReq       (iReq),
    .iWe        (iWe),
    .iAddress   (iAddress),
    .iWriteData (iWriteData),
    .iByteEn    (iByteEn),
    .oReadData  (oReadData),
    .oStall     (oStall),
    .oMemReq    (oMemReq),
    .oMemWe     (oMemWe),
    .oMemAddr   (oMemAddr),
    .oMemWData  (oMemWData),
    .oMemBe     (oMemBe),
    .iMemAck    (iMemAck),
    .iMemRData  (iMemRData)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          delay;
    logic        miss;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    int          stalls;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] fill_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_vec = 0;
  int          n_bad = 0;
  int          wr_count = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          vec_idx = -1;
  logic        force_ack = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %0h, expected %0h", vec_idx, name, act, exp);
    end
  endtask

  // Backing memory: acks after ack_delay idle cycles per beat, also drives stray acks on request.
  always @(negedge iClk) begin
    #2;
    if (oMemReq) begin
      if (wait_cnt >= ack_delay) begin
        iMemAck   = 1'b1;
        iMemRData = mem_rd(oMemAddr);
        wait_cnt  = 0;
      end else begin
        iMemAck   = 1'b0;
        iMemRData = 32'h0;
        wait_cnt++;
      end
    end else begin
      iMemAck   = force_ack;
      iMemRData = 32'h0;
      wait_cnt  = 0;
    end
  end

  // Records each beat the DUT will accept at the coming rising edge.
  always @(negedge iClk) begin
    #3;
    if (oMemReq && iMemAck) begin
      if (oMemWe) begin
        logic [31:0] w;
        w = mem_rd(oMemAddr);
        for (int b = 0; b < 4; b++) begin
          if (oMemBe[b]) w[8*b +: 8] = oMemWData[8*b +: 8];
        end
        mem[oMemAddr] = w;
        wr_count++;
      end else begin
        fill_q.push_back(oMemAddr);
      end
    end
  end

  task automatic access(input vec_t v);
    exp_t        e;
    exp_t        got;
    int          stalls;
    int          wr0;
    logic [31:0] base;
    @(negedge iClk);
    fill_q.delete();
    wr0        = wr_count;
    ack_delay  = v.delay;
    iReq       = 1'b1;
    iWe        = v.we;
    iAddress   = v.addr;
    iWriteData = v.wdata;
    iByteEn    = v.be;
    e.rd       = v.we ? 32'h0 : v.exp_rd;
    e.stalls   = v.we ? (2 + v.delay) : (v.miss ? (1 + LW * (v.delay + 1)) : 0);
    sb_q.push_back(e);
    #1;
    stalls = 0;
    while (oStall && stalls < 200) begin
      stalls++;
      @(negedge iClk);
      #1;
    end
    got = sb_q.pop_front();
    chk("stall_cycles", stalls, got.stalls);
    chk("read_data", oReadData, got.rd);
    chk("mem_writes", wr_count - wr0, {31'h0, v.we});
    if (!v.we && v.miss) begin
      base = {v.addr[31:4], 4'h0};
      chk("fill_beats", fill_q.size(), LW);
      for (int k = 0; k < fill_q.size() && k < LW; k++) begin
        chk("fill_addr", fill_q[k], base + 32'(4 * k));
      end
    end else begin
      chk("fill_beats", fill_q.size(), 0);
    end
    @(negedge iClk);
    iReq = 1'b0;
    iWe  = 1'b0;
    #1;
    chk("idle_stall", oStall, 0);
    chk("idle_memreq", oMemReq, 0);
    chk("idle_rdata", oReadData, 0);
  endtask

  task automatic chk_all_zero();
    chk("rst_stall", oStall, 0);
    chk("rst_memreq", oMemReq, 0);
    chk("rst_memwe", oMemWe, 0);
    chk("rst_memaddr", oMemAddr, 0);
    chk("rst_memwdata", oMemWData, 0);
    chk("rst_membe", oMemBe, 0);
    chk("rst_rdata", oReadData, 0);
  endtask

  vec_t vecs[13];

  initial begin
    for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);

    vecs[0]  = '{1'b0, 32'h100,  32'h0,        4'h0, 0, 1'b1, 32'hA0};
    vecs[1]  = '{1'b0, 32'h10C,  32'h0,        4'h0, 0, 1'b0, 32'hA3};
    vecs[2]  = '{1'b1, 32'h104,  32'hDEADBEEF, 4'hF, 3, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h104,  32'h0,        4'h0, 0, 1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 32'h2000, 32'h12345678, 4'hF, 1, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h2000, 32'h0,        4'h0, 0, 1'b1, 32'h12345678};
    vecs[6]  = '{1'b0, 32'h500,  32'h0,        4'h0, 1, 1'b1, 32'hC0DE0500};
    vecs[7]  = '{1'b0, 32'h100,  32'h0,        4'h0, 0, 1'b1, 32'hA0};
    vecs[8]  = '{1'b0, 32'h108,  32'h0,        4'h0, 0, 1'b0, 32'hA2};
    vecs[9]  = '{1'b1, 32'h108,  32'h11223344, 4'hF, 0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h108,  32'h0,        4'h0, 0, 1'b0, 32'h11223344};
    vecs[11] = '{1'b1, 32'h108,  32'h0000AB00, 4'b0010, 2, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'h108,  32'h0,        4'h0, 0, 1'b0, 32'h1122AB44};

    // Reset held with a pending load: outputs must stay quiet.
    iRst       = 1'b1;
    iReq       = 1'b1;
    iWe        = 1'b0;
    iAddress   = 32'h100;
    iWriteData = 32'h0;
    iByteEn    = 4'h0;
    #1;
    chk_all_zero();
    iReq = 1'b0;
    repeat (2) @(negedge iClk);
    iRst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      vec_idx = i;
      access(vecs[i]);
    end

    // Evict 0x100, then abort its refill with reset after two beats.
    vec_idx = 13;
    access('{1'b0, 32'h500, 32'h0, 4'h0, 0, 1'b1, 32'hC0DE0500});
    vec_idx = 14;
    @(negedge iClk);
    fill_q.delete();
    ack_delay = 0;
    iReq      = 1'b1;
    iWe       = 1'b0;
    iAddress  = 32'h100;
    for (int k = 0; k < 50 && fill_q.size() < 2; k++) begin
      @(negedge iClk);
      #5;
    end
    chk("beats_before_rst", fill_q.size(), 2);
    @(negedge iClk);
    iRst = 1'b1;
    #1;
    chk_all_zero();
    iReq = 1'b0;
    @(negedge iClk);
    iRst = 1'b0;
    vec_idx = 15;
    access('{1'b0, 32'h100, 32'h0, 4'h0, 0, 1'b1, 32'hA0});

    // Stray acks while idle must have no effect.
    vec_idx = 16;
    @(negedge iClk);
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge iClk);
      #3;
      chk("stray_ack_stall", oStall, 0);
      chk("stray_ack_memreq", oMemReq, 0);
    end
    @(negedge iClk);
    force_ack = 1'b0;
    vec_idx = 17;
    access('{1'b0, 32'h104, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_cache_m.md
DATA_CACHE_M -- requirements
Module: data_cache_m

Interface
REQ-001 Parameter: SETS, 64, number of direct-mapped lines (power of two).
REQ-002 Parameter: LINE_WORDS, 4, 32-bit words per line (power of two).
REQ-003 Ports: iClk  in  1  single clock, rising edge; iRst  in  1  asynchronous, active-high reset.
REQ-004 Ports: iReq  in  1  memory-stage access valid; iWe  in  1  store when 1, load when 0.
REQ-005 Ports: iAddress  in  32  byte address from memory-stage ALU result; iWriteData  in  32  store data; iByteEn  in  4  store byte lanes.
REQ-006 Ports: oReadData  out  32  load word, aligned; oStall  out  1  stall request to hazard unit (F, D, E, M held).
REQ-007 Ports: oMemReq  out  1; oMemWe  out  1; oMemAddr  out  32; oMemWData  out  32; oMemBe  out  4  backing-memory request.
REQ-008 Ports: iMemAck  in  1  backing memory accepts or completes one beat; iMemRData  in  32  read data, valid with iMemAck.

Function
REQ-009 Address split SHALL be: offset [3:2], index [9:4], tag [31:10] (defaults); widths derive from the parameters.
REQ-010 Policy SHALL be write-through, no-write-allocate, read-allocate.
REQ-011 FSM states SHALL be IDLE, REFILL, WRITE, RESPOND.
REQ-012 IDLE, iReq=0: oStall=0, oMemReq=0, no state change.
REQ-013 IDLE, load hit (valid and tag match): oReadData = stored word combinationally, oStall=0, zero added latency.
REQ-014 IDLE, load miss: oStall=1 the same cycle; next state REFILL with beat counter 0.
REQ-015 REFILL: oMemReq=1, oMemWe=0, oMemAddr = {tag,index,counter,2'b00}; on iMemAck write iMemRData into line word [counter], counter++.
REQ-016 REFILL: after the LINE_WORDS-th ack, set tag and valid for the line and go to RESPOND; oStall=1 throughout REFILL.
REQ-017 RESPOND: oStall=0, oReadData = requested word from the newly filled line; next state IDLE. Lasts exactly one cycle.
REQ-018 IDLE, store (hit or miss): oStall=1; next state WRITE.
REQ-019 WRITE: oMemReq=1, oMemWe=1, oMemAddr=iAddress, oMemWData=iWriteData, oMemBe=iByteEn until iMemAck.
REQ-020 On the WRITE ack, if the line hits, merge the enabled bytes into the cached word; the next state is RESPOND; a miss SHALL NOT allocate.
REQ-021 iReq, iWe, iAddress, iWriteData and iByteEn SHALL be held stable by upstream while oStall=1; the block samples them combinationally and never latches them.
REQ-022 iMemAck while oMemReq=0 SHALL be ignored.
REQ-023 A conflicting refill SHALL overwrite the previous line; no dirty state exists.
REQ-024 oReadData SHALL be 0 when not in a load hit or RESPOND for a load.

Reset
REQ-025 iRst SHALL asynchronously clear all valid bits, set state IDLE and counter 0, and drive oStall=0, oMemReq=0, oMemWe=0, oMemAddr=0, oMemWData=0, oMemBe=0 and oReadData=0.
REQ-026 Reset asserted during REFILL or WRITE SHALL abandon the transaction; a partially filled line SHALL remain invalid.
REQ-027 Tag and data arrays need no reset.

Structure
REQ-028 A shared package SHALL hold the FSM state enum and the default SETS and LINE_WORDS constants.
REQ-029 Tag, valid and data storage SHALL be one sub-module, cache_array, with one read port and a byte-enabled write port.
REQ-030 Integration point: between the memory-stage pipeline register and data memory; oStall is ORed into the hazard unit's stall outputs.

Verification
REQ-031 Cold load 0x100, ack every cycle with data 0xA0..0xA3: oStall=1 for 5 cycles, then RESPOND oReadData=0xA0. Repeat load 0x10C: hit, 0xA3, no stall.
REQ-032 Store 0xDEADBEEF to 0x104, be=4'hF, line valid, ack after 3 cycles: memory write seen once; a later load of 0x104 hits and returns 0xDEADBEEF.
REQ-033 Store to uncached 0x2000 then load 0x2000: the store does not allocate, and the load triggers a 4-beat refill at 0x2000-0x200C.
REQ-034 Load 0x100, then load 0x500 (same index 16): 0x500 refills and evicts; load 0x100 misses again.
REQ-035 Assert iRst after the second refill beat: all outputs zero immediately, state IDLE; load 0x100 then misses and refills fully.
REQ-036 Byte store be=4'b0010 data 0x0000AB00 to cached 0x108 holding 0x11223344: the cached word becomes 0x1122AB44.
